// File: rtl/conv_mac_288_pkg.sv
// Shared constants, layer codes and FSM state type for the conv_mac_288 dot-product engine.
package conv_mac_288_pkg;

   localparam int DATA_LEN      = 16;
   localparam int N_ELEM        = 288;
   localparam int VEC_W         = N_ELEM * DATA_LEN;
   localparam int ACC_W         = 2 * DATA_LEN + 9;
   localparam int LANES_DEFAULT = 16;
   localparam int CHUNKS        = N_ELEM / LANES_DEFAULT;

   // Layer select codes shared with the layer sequencer.
   localparam logic [3:0] LAYER0 = 4'd1;
   localparam logic [3:0] LAYER1 = 4'd2;
   localparam logic [3:0] LAYER2 = 4'd3;
   localparam logic [3:0] LAYER3 = 4'd4;
   localparam logic [3:0] AFFINE = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_OUT
   } state_t;

   function automatic int chunks_for(input int lanes);
      return N_ELEM / lanes;
   endfunction

   function automatic logic is_layer(input logic [3:0] c);
      return (c == LAYER0) || (c == LAYER1) || (c == LAYER2) || (c == LAYER3);
   endfunction

endpackage

// File: rtl/conv_mac_288_if.sv
// Weight/activation/result bundle between the weight store, the activation feeder and conv_mac_288.
interface conv_mac_288_if
   import conv_mac_288_pkg::*;
   ();

   logic [3:0]          cs;
   logic                w_valid;
   logic [VEC_W-1:0]    w_q;
   logic                d_valid;
   logic [VEC_W-1:0]    d_q;
   logic                d_ready;
   logic                valid;
   logic [DATA_LEN-1:0] q;

   modport master (
      output cs, w_valid, w_q, d_valid, d_q,
      input  d_ready, valid, q
   );

   modport slave (
      input  cs, w_valid, w_q, d_valid, d_q,
      output d_ready, valid, q
   );

endinterface

// File: rtl/conv_mac_288_mac_lane_sum.sv
// Combinational signed sum of LANES weight*activation products, sign-extended to ACC_W bits.
module mac_lane_sum
   import conv_mac_288_pkg::*;
#(
   parameter int LANES = LANES_DEFAULT
) (
   input  logic [LANES*DATA_LEN-1:0] w_lanes,
   input  logic [LANES*DATA_LEN-1:0] d_lanes,
   output logic signed [ACC_W-1:0]   sum
);

   logic signed [2*DATA_LEN-1:0] prod;

   // NOTE: blocking assignments here on purpose -- this is a combinational
   // running sum, each iteration must see the previous partial result.
   always_comb begin
      sum  = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         prod = signed'(w_lanes[i*DATA_LEN +: DATA_LEN]) * signed'(d_lanes[i*DATA_LEN +: DATA_LEN]);
         sum  = sum + {{(ACC_W-2*DATA_LEN){prod[2*DATA_LEN-1]}}, prod};
      end
   end

endmodule

// File: rtl/conv_mac_288.sv
// 288-element fixed-point dot-product engine: LANES MACs per cycle, then shift, saturate, optional ReLU.
module conv_mac_288
   import conv_mac_288_pkg::*;
#(
   parameter int LANES = LANES_DEFAULT,
   parameter int FRAC  = 8
) (
   input logic           clk,
   input logic           rst,
   conv_mac_288_if.slave bus
);

   localparam int N_CHUNK = chunks_for(LANES);
   localparam int K_W     = $clog2(N_CHUNK);
   localparam int LANE_W  = LANES * DATA_LEN;

   localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

   state_t                    state, state_n;
   logic [K_W-1:0]            k;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   chunk_sum;
   logic signed [ACC_W-1:0]   shifted;
   logic [DATA_LEN-1:0]       sat;
   logic [DATA_LEN-1:0]       fin;
   logic [VEC_W-1:0]          win;
   logic [3:0]                cs_prev;
   logic [LANE_W-1:0]         w_lanes;
   logic [LANE_W-1:0]         d_lanes;
   logic                      abort;
   logic                      accept;
   logic                      last_chunk;

   // A layer switch or the weight store dropping its vector kills the pass.
   assign abort      = (bus.cs != cs_prev) || ((state == S_MAC) && !bus.w_valid);
   assign accept     = (state == S_IDLE) && bus.d_valid && bus.w_valid && !abort;
   assign last_chunk = (k == K_W'(N_CHUNK-1));
   assign bus.d_ready = (state == S_IDLE) && !rst;

   assign w_lanes = bus.w_q[k*LANE_W +: LANE_W];
   assign d_lanes = win[k*LANE_W +: LANE_W];

   mac_lane_sum #(.LANES(LANES)) u_lane_sum (
      .w_lanes (w_lanes),
      .d_lanes (d_lanes),
      .sum     (chunk_sum)
   );

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (accept) state_n = S_MAC;
            S_MAC:   if (last_chunk) state_n = S_OUT;
            S_OUT:   state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_comb begin
      shifted = acc >>> FRAC;
      sat     = shifted[DATA_LEN-1:0];
      if (shifted > Q_MAX) begin
         sat = Q_MAX[DATA_LEN-1:0];
      end else if (shifted < Q_MIN) begin
         sat = Q_MIN[DATA_LEN-1:0];
      end
      fin = (is_layer(bus.cs) && sat[DATA_LEN-1]) ? '0 : sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         k         <= '0;
         acc       <= '0;
         bus.q     <= '0;
         bus.valid <= 1'b0;
         cs_prev   <= bus.cs;
      end else begin
         state     <= state_n;
         cs_prev   <= bus.cs;
         bus.valid <= 1'b0;
         if (!abort) begin
            unique case (state)
               S_IDLE: begin
                  if (accept) begin
                     k   <= '0;
                     acc <= '0;
                  end
               end
               S_MAC: begin
                  acc <= acc + chunk_sum;
                  k   <= k + 1'b1;
               end
               S_OUT: begin
                  bus.q     <= fin;
                  bus.valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the window register is pure data storage, only read after a load,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         win <= bus.d_q;
      end
   end

endmodule

// File: doc/conv_mac_288.md
# conv_mac_288

Dot-product engine directly downstream of `weight_store_23`. It takes the 288-entry weight vector once the store raises `valid`, accepts 288-entry activation windows over a valid/ready handshake, and multiply-accumulates them over 18 cycles with 16 parallel lanes. Each result is rescaled, saturated and optionally ReLU-clipped, then emitted as one `data_len`-bit value. It serves the LAYER0..LAYER3 conv passes and the AFFINE pass selected by `cs`.

## Interface
Parameters:
- `LANES`, 16: multipliers per cycle. Must divide 288; legal values 8, 16, 32.
- `FRAC`, 8: fractional bits of the signed fixed-point format.

Ports:
- `clk` in, 1: single clock. All logic is on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `cs` in, 4: layer select using the `LAYER0..LAYER3` and `AFFINE` codes from `state_layer_data.v`.
- `w_valid` in, 1: weight vector stable. Driven by `weight_store_23.valid`.
- `w_q` in, 288*`data_len`: weights. Element i is `w_q[i*data_len +: data_len]`.
- `d_valid` in, 1: activation window offered.
- `d_q` in, 288*`data_len`: activations, same packing as `w_q`.
- `d_ready` out, 1: engine can accept a window.
- `valid` out, 1: result strobe, one cycle wide.
- `q` out, `data_len`: result.

## Operation
- Number format: signed two's complement, `data_len` bits, `FRAC` fractional bits.
- Products are 2*`data_len` bits wide.
- Accumulator is 2*`data_len`+9 bits wide (288 < 2^9), so it never overflows.
- Finalise step:
  - Arithmetic right shift of the accumulator by `FRAC`.
  - Saturate to [-2^(data_len-1), 2^(data_len-1)-1].
  - Apply ReLU (negative becomes 0) when `cs` is any LAYERn. When `cs` == AFFINE, no ReLU.
- FSM states:
  - IDLE: `d_ready`=1. If `d_valid` && `w_valid`, latch `d_q` into the window register, clear the accumulator and `k`, go to MAC.
  - MAC: add the sum of products for elements `k*LANES .. k*LANES+LANES-1`, then `k++`. After the final chunk (k = 288/LANES-1), go to OUT.
  - OUT: register the finalised value into `q`, pulse `valid`, go to IDLE.
- `w_q` is sampled live during MAC and is never copied; the store holds it stable while `w_valid`=1.
- Abort: `cs` is registered into `cs_prev`. When `cs != cs_prev`, or `w_valid` falls while in MAC, the FSM returns to IDLE with no `valid` pulse. This abort takes priority over any other transition in that cycle.
- `d_valid` is ignored outside IDLE, and also when `w_valid`=0.
- `q` holds its last value between results.

## Timing
- Reset values: state IDLE, `d_ready`=0 during reset then 1, `valid`=0, `q`=0, accumulator 0, `k`=0, `cs_prev`=`cs`.
- Accept occurs on edge E0, where `d_valid` && `d_ready` && `w_valid`. `d_ready` is low from E0.
- MAC chunks land on edges E1..E(288/LANES). With the default `LANES`=16 that is E1..E18.
- Result is registered on E19: `valid`=1 and `q` are valid for the single cycle after E19. `d_ready`=1 in that same cycle.
- Throughput is one window per 20 cycles (default). Back-to-back accept is allowed on E20.
- A `cs` change seen on edge Ea aborts the operation. `d_ready`=1 after Ea+1, since detection is registered.
- `rst` asserted mid-MAC returns to reset values on the next edge. No `valid` pulse is produced.

## Structure
- Shared package/include carries:
  - `data_len`, from `num_data.v`.
  - The layer codes, from `state_layer_data.v`.
  - The derived constants `ACC_W` = 2*`data_len`+9 and `CHUNKS` = 288/`LANES`.
- Sub-module `mac_lane_sum`: combinational signed sum of `LANES` products, producing an `ACC_W`-bit result. It is instantiated once.
- The FSM, accumulator and finalise logic stay in the top level.

## Test plan
Settings for all scenarios: `data_len`=16, `FRAC`=8, `LANES`=16.
1. **Single element:** w[0]=0x0100, other weights 0; d[0]=0x0300; `cs`=LAYER0 -> `valid` one cycle after E19, `q`=0x0300.
2. **ReLU vs. AFFINE:** w[287]=0xFF00 (-1.0), d[287]=0x0200 -> under LAYER1, `q`=0x0000; under AFFINE, `q`=0xFE00.
3. **Saturation:** all weights 0x0100, all data 0x0080 (sum 144.0) -> `q`=0x7FFF. The same with data 0xFF80 under AFFINE -> `q`=0x8000.
4. **Handshake gating:** `d_valid`=1 with `w_valid`=0 for 30 cycles -> no accept and no `valid`. Raise `w_valid` -> accept on the next edge; two back-to-back windows give `valid` pulses 20 cycles apart.
5. **Abort on cs change:** change `cs` LAYER2->LAYER3 at E10 -> no `valid`, `d_ready`=1 by E12, and the next window yields the correct result.
6. **Reset mid-operation:** assert `rst` at E7 -> all outputs return to reset values, no `valid` pulse, and normal operation resumes after deassertion.
